// File: rtl/eth_port_ingress_buf.sv
// rtl/eth_port_ingress_buf.sv - store-and-forward ingress packet buffer for one switch port
// Complete packets are committed before replay; malformed and oversize packets are discarded.
module eth_port_ingress_buf #(
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_WORDS = 16,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [31:0]              wrData,
  input  logic                     wrSop,
  input  logic                     wrEop,
  input  logic                     wrValid,
  output logic                     wrReady,
  input  logic                     portStall,
  output logic [31:0]              outData,
  output logic                     outSop,
  output logic                     outEop,
  output logic [$clog2(DEPTH):0]   pktCount,
  output logic [CNT_W-1:0]         dropCount,
  output logic [CNT_W-1:0]         errCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state;

  logic [31:0]   mem_data [DEPTH];
  logic          mem_eop  [DEPTH];
  logic [PW-1:0] wr_spec, wr_commit, rd_ptr, used, spec_base;
  logic [CW-1:0] word_cnt, cnt_next;
  logic          ready_en, accept;
  logic          do_store, do_commit, drop_inc, err_inc, read_done;

  assign used      = wr_spec - rd_ptr;
  assign wrReady   = ready_en && (used != PW'(DEPTH));
  assign accept    = wrValid && wrReady;
  assign read_done = (r_state == R_SEND) && outEop;

  // spec_base is where the accepted word lands; rewinds drop the speculative tail
  always_comb begin
    do_store  = 1'b0;
    do_commit = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    w_next    = w_state;
    spec_base = wr_spec;
    cnt_next  = word_cnt;
    if (accept) begin
      if (wrSop) begin
        // a sop in W_DROP does not recount the already dropped packet
        drop_inc  = (w_state == W_PKT);
        spec_base = wr_commit;
        do_store  = 1'b1;
        cnt_next  = CW'(1);
        do_commit = wrEop;
        w_next    = wrEop ? W_IDLE : W_PKT;
      end else begin
        case (w_state)
          W_IDLE: err_inc = 1'b1;
          W_PKT: begin
            if (word_cnt == CW'(MAX_PKT_WORDS)) begin
              drop_inc  = 1'b1;
              spec_base = wr_commit;
              w_next    = wrEop ? W_IDLE : W_DROP;
            end else begin
              do_store  = 1'b1;
              cnt_next  = word_cnt + CW'(1);
              do_commit = wrEop;
              if (wrEop) w_next = W_IDLE;
            end
          end
          default: if (wrEop) w_next = W_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      mem_data[spec_base[AW-1:0]] <= wrData;
      mem_eop[spec_base[AW-1:0]]  <= wrEop;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ready_en  <= 1'b0;
      w_state   <= W_IDLE;
      word_cnt  <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
      dropCount <= '0;
      errCount  <= '0;
    end else begin
      ready_en  <= 1'b1;
      w_state   <= w_next;
      word_cnt  <= cnt_next;
      wr_spec   <= do_store ? spec_base + PW'(1) : spec_base;
      if (do_commit) wr_commit <= spec_base + PW'(1);
      if (drop_inc && dropCount != '1) dropCount <= dropCount + CNT_W'(1);
      if (err_inc && errCount != '1)   errCount  <= errCount + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pktCount <= '0;
    end else if (do_commit && !read_done) begin
      pktCount <= pktCount + PW'(1);
    end else if (read_done && !do_commit) begin
      pktCount <= pktCount - PW'(1);
    end
  end

  // R_GAP is the single idle cycle after eop; a waiting packet may start from it
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= R_IDLE;
      rd_ptr  <= '0;
      outData <= '0;
      outSop  <= 1'b0;
      outEop  <= 1'b0;
    end else begin
      case (r_state)
        R_SEND: begin
          if (outEop) begin
            r_state <= R_GAP;
            outData <= '0;
            outSop  <= 1'b0;
            outEop  <= 1'b0;
          end else begin
            outData <= mem_data[rd_ptr[AW-1:0]];
            outSop  <= 1'b0;
            outEop  <= mem_eop[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + PW'(1);
          end
        end
        default: begin
          if (pktCount != '0 && !portStall) begin
            r_state <= R_SEND;
            outData <= mem_data[rd_ptr[AW-1:0]];
            outSop  <= 1'b1;
            outEop  <= mem_eop[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + PW'(1);
          end else begin
            r_state <= R_IDLE;
            outData <= '0;
            outSop  <= 1'b0;
            outEop  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_port_ingress_buf.sv
// tb/tb_eth_port_ingress_buf.sv - self-checking bench for eth_port_ingress_buf
// Vector table, directed corner sequences, and randomized packets against a packet-level model.
module tb_eth_port_ingress_buf;
  localparam int DEPTH = 64;
  localparam int MAXW  = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0, resetN = 1'b0;
  logic [31:0] wrData = '0;
  logic wrSop = 1'b0, wrEop = 1'b0, wrValid = 1'b0, portStall = 1'b0;
  logic wrReady, outSop, outEop;
  logic [31:0] outData;
  logic [$clog2(DEPTH):0] pktCount;
  logic [CNT_W-1:0] dropCount, errCount;

  eth_port_ingress_buf #(.DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .wrData(wrData), .wrSop(wrSop), .wrEop(wrEop),
    .wrValid(wrValid), .wrReady(wrReady), .portStall(portStall), .outData(outData),
    .outSop(outSop), .outEop(outEop), .pktCount(pktCount), .dropCount(dropCount),
    .errCount(errCount)
  );

  always #5 clk = ~clk;

  typedef struct {logic sop; logic eop; logic [31:0] data; int cyc;} word_t;
  typedef struct {bit v; bit s; bit e; int pkt; int drop; int err;} vec_t;

  int checks = 0, failures = 0, cyc = 0;
  word_t log_q[$];
  word_t exp_q[$];
  logic in_pkt = 1'b0;
  int exp_drop, exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetN) in_pkt <= 1'b0;
    else if (outSop || outEop || in_pkt || outData != 0) begin
      log_q.push_back('{outSop, outEop, outData, cyc});
      in_pkt <= !outEop;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit s, input bit e);
    int n = 0;
    wrData = d; wrSop = s; wrEop = e; wrValid = 1'b1;
    while (!wrReady && n < 300) begin
      portStall = 1'b0;
      tick();
      n++;
    end
    if (!wrReady) check("send_ready_timeout", wrReady, 1);
    tick();
    wrValid = 1'b0; wrSop = 1'b0; wrEop = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0; wrValid = 1'b0; wrSop = 1'b0; wrEop = 1'b0; wrData = '0; portStall = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
    tick();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    portStall = 1'b0;
    while ((pktCount != 0 || outSop || in_pkt) && n < limit) begin
      tick();
      n++;
    end
    check("drain_timeout", (n < limit), 1);
    repeat (3) tick();
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), log_q[i].data, exp_q[i].data);
      check($sformatf("%s_sop%0d", tag, i), log_q[i].sop, exp_q[i].sop);
      check($sformatf("%s_eop%0d", tag, i), log_q[i].eop, exp_q[i].eop);
      if (i > 0 && log_q[i].sop)
        check($sformatf("%s_gap%0d", tag, i), (log_q[i].cyc - log_q[i-1].cyc) >= 2, 1);
    end
  endtask

  task automatic gen_normal();
    int len = $urandom_range(1, MAXW);
    for (int w = 0; w < len; w++) begin
      logic [31:0] d = $urandom;
      exp_q.push_back('{w == 0, w == len - 1, d, 0});
      portStall = ($urandom_range(0, 3) == 0);
      send(d, w == 0, w == len - 1);
    end
  endtask

  vec_t vt[11];
  bit ready_all;

  initial begin
    vt[0]  = '{1, 0, 1, 0, 0, 1};
    vt[1]  = '{0, 0, 0, 0, 0, 1};
    vt[2]  = '{1, 1, 1, 1, 0, 1};
    vt[3]  = '{1, 1, 0, 1, 0, 1};
    vt[4]  = '{1, 0, 0, 1, 0, 1};
    vt[5]  = '{1, 1, 0, 1, 1, 1};
    vt[6]  = '{1, 0, 1, 2, 1, 1};
    vt[7]  = '{1, 0, 0, 2, 1, 2};
    vt[8]  = '{1, 1, 0, 2, 1, 2};
    vt[9]  = '{0, 0, 0, 2, 1, 2};
    vt[10] = '{1, 0, 1, 3, 1, 2};

    #1;
    check("rst_wrReady", wrReady, 0);
    check("rst_outSop", outSop, 0);
    check("rst_pktCount", pktCount, 0);
    do_reset();
    check("rst_release_wrReady", wrReady, 1);
    check("rst_dropCount", dropCount, 0);
    check("rst_errCount", errCount, 0);

    // vector table with the read side stalled
    portStall = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wrValid = vt[i].v; wrSop = vt[i].s; wrEop = vt[i].e; wrData = 32'h100 + i;
      tick();
      check($sformatf("vec%0d_pkt", i), pktCount, vt[i].pkt);
      check($sformatf("vec%0d_drop", i), dropCount, vt[i].drop);
      check($sformatf("vec%0d_err", i), errCount, vt[i].err);
    end
    wrValid = 1'b0; wrSop = 1'b0; wrEop = 1'b0;
    check("vec_outSop_stalled", outSop, 0);
    exp_q.push_back('{1, 1, 32'h102, 0});
    exp_q.push_back('{1, 0, 32'h105, 0});
    exp_q.push_back('{0, 1, 32'h106, 0});
    exp_q.push_back('{1, 0, 32'h108, 0});
    exp_q.push_back('{0, 1, 32'h10A, 0});
    drain(60);
    compare_log("vec");

    // 4-word packet latency and framing
    do_reset();
    send(32'h11, 1, 0); send(32'h22, 0, 0); send(32'h33, 0, 0); send(32'h44, 0, 1);
    check("t1_pkt_after_commit", pktCount, 1);
    check("t1_no_early_sop", outSop, 0);
    tick();
    check("t1_sop", outSop, 1); check("t1_d0", outData, 32'h11); check("t1_eop0", outEop, 0);
    tick();
    check("t1_d1", outData, 32'h22); check("t1_sop1", outSop, 0);
    tick();
    check("t1_d2", outData, 32'h33);
    tick();
    check("t1_d3", outData, 32'h44); check("t1_eop", outEop, 1);
    tick();
    check("t1_idle_sop", outSop, 0); check("t1_idle_eop", outEop, 0);
    check("t1_pkt_end", pktCount, 0);

    // single-word packet followed immediately by another
    do_reset();
    send(32'hAB, 1, 1); send(32'hC1, 1, 0); send(32'hC2, 0, 1);
    repeat (10) tick();
    check("t2_len", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t2_ab", log_q[0].data, 32'hAB);
      check("t2_ab_sop", log_q[0].sop, 1);
      check("t2_ab_eop", log_q[0].eop, 1);
      check("t2_c1", log_q[1].data, 32'hC1);
      check("t2_c1_sop", log_q[1].sop, 1);
      check("t2_gap", log_q[1].cyc - log_q[0].cyc, 2);
      check("t2_c2_eop", log_q[2].eop, 1);
    end

    // stall while writing three packets, mid-packet stall ignored
    do_reset();
    portStall = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int w = 0; w < 3; w++) begin
        exp_q.push_back('{w == 0, w == 2, 32'h300 + 16 * p + w, 0});
        send(32'h300 + 16 * p + w, w == 0, w == 2);
      end
    repeat (4) tick();
    check("t3_pkt3", pktCount, 3);
    check("t3_no_out", log_q.size(), 0);
    portStall = 1'b0;
    for (int n = 0; n < 10 && !outSop; n++) tick();
    check("t3_started", outSop, 1);
    portStall = 1'b1;
    repeat (8) tick();
    check("t3_one_pkt", log_q.size(), 3);
    check("t3_pkt2", pktCount, 2);
    portStall = 1'b0;
    repeat (20) tick();
    compare_log("t3");
    if (log_q.size() == 9) check("t3_gap23", log_q[6].cyc - log_q[5].cyc, 2);

    // restart discards partial packet P
    do_reset();
    send(32'h501, 1, 0); send(32'h502, 0, 0);
    send(32'h601, 1, 0); send(32'h602, 0, 0); send(32'h603, 0, 1);
    exp_q.push_back('{1, 0, 32'h601, 0});
    exp_q.push_back('{0, 0, 32'h602, 0});
    exp_q.push_back('{0, 1, 32'h603, 0});
    repeat (12) tick();
    check("t4_drop", dropCount, 1);
    compare_log("t4");

    // oversize packet and stray word
    do_reset();
    ready_all = 1'b1;
    for (int i = 0; i < MAXW + 1; i++) begin
      ready_all &= wrReady;
      send(32'h700 + i, i == 0, i == MAXW);
    end
    ready_all &= wrReady;
    repeat (8) tick();
    check("t5_ready_held", ready_all, 1);
    check("t5_drop", dropCount, 1);
    check("t5_no_out", log_q.size(), 0);
    check("t5_pkt", pktCount, 0);
    send(32'h7FF, 0, 1);
    check("t5_err", errCount, 1);
    check("t5_drop_same", dropCount, 1);

    // fill to DEPTH, then reset mid-transfer
    do_reset();
    portStall = 1'b1;
    for (int p = 0; p < DEPTH / MAXW; p++)
      for (int w = 0; w < MAXW; w++) begin
        wrData = 32'h800 + w; wrSop = (w == 0); wrEop = (w == MAXW - 1); wrValid = 1'b1;
        tick();
      end
    wrValid = 1'b0; wrSop = 1'b0; wrEop = 1'b0;
    check("t6_full", wrReady, 0);
    check("t6_pkt", pktCount, DEPTH / MAXW);
    portStall = 1'b0;
    repeat (3) tick();
    check("t6_mid_xfer", outSop | outEop | (outData != 0), 1);
    resetN = 1'b0;
    #1;
    check("t6_rst_data", outData, 0);
    check("t6_rst_sop", outSop, 0);
    check("t6_rst_eop", outEop, 0);
    check("t6_rst_ready", wrReady, 0);
    check("t6_rst_pkt", pktCount, 0);
    repeat (2) tick();
    resetN = 1'b1;
    check("t6_ready_before_edge", wrReady, 0);
    tick();
    check("t6_ready_after_edge", wrReady, 1);
    check("t6_pkt_after", pktCount, 0);
    log_q.delete();
    send(32'h901, 1, 0); send(32'h902, 0, 1);
    exp_q.push_back('{1, 0, 32'h901, 0});
    exp_q.push_back('{0, 1, 32'h902, 0});
    repeat (10) tick();
    compare_log("t6");

    // randomized packets against the packet-level model
    do_reset();
    exp_drop = 0; exp_err = 0;
    for (int p = 0; p < 40; p++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 6) begin
        int flen = $urandom_range(1, 5);
        for (int w = 0; w < flen; w++) send($urandom, w == 0, 0);
        exp_drop++;
        gen_normal();
      end else if (kind == 7) begin
        int olen = $urandom_range(MAXW + 1, MAXW + 4);
        for (int w = 0; w < olen; w++) send($urandom, w == 0, w == olen - 1);
        exp_drop++;
      end else if (kind == 8) begin
        send($urandom, 0, $urandom_range(0, 1));
        exp_err++;
      end else begin
        gen_normal();
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain(2000);
    check("rand_drop", dropCount, exp_drop);
    check("rand_err", errCount, exp_err);
    compare_log("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
